// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: region select bit, MMIO register map, STATUS bits.
package dmem_pkg;
    localparam int MMIO_SEL_BIT = 31;

    typedef enum logic [1:0] {
        REG_CYCLE  = 2'd0,
        REG_LED    = 2'd1,
        REG_TCMP   = 2'd2,
        REG_STATUS = 2'd3
    } mmio_reg_e;

    localparam int STATUS_HIT = 0;
endpackage

// File: rtl/dmem_mmio_regs.sv
// MMIO register window: free-running CYCLE counter, LED, timer compare and sticky STATUS.hit.
// Latency: registers update on the rising edge; rdata is combinational and shows post-edge (write-first) values.
module dmem_mmio_regs
    import dmem_pkg::*;
#(
    parameter int LED_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sel,
    input  logic                 wren,
    input  logic [1:0]           offset,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq_timer
);
    logic [31:0]          cycle_q, cycle_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          tcmp_q, tcmp_d;
    logic                 hit_q, hit_d;
    mmio_reg_e            reg_sel;

    assign reg_sel = mmio_reg_e'(offset);

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        led_d   = led_q;
        tcmp_d  = tcmp_q;
        hit_d   = hit_q;
        if (sel && wren) begin
            case (reg_sel)
                REG_LED:    led_d  = wdata[LED_WIDTH-1:0];
                REG_TCMP:   tcmp_d = wdata;
                REG_STATUS: if (wdata[STATUS_HIT]) hit_d = 1'b0;
                default:    ;
            endcase
        end
        // Set is evaluated after clear so a coincident hit wins.
        if ((cycle_q == tcmp_q) && (tcmp_q != 32'd0)) hit_d = 1'b1;
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            REG_CYCLE:  rdata = cycle_d;
            REG_LED:    rdata = 32'(led_d);
            REG_TCMP:   rdata = tcmp_d;
            REG_STATUS: rdata[STATUS_HIT] = hit_d;
            default:    rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q <= 32'd0;
            led_q   <= '0;
            tcmp_q  <= 32'd0;
            hit_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            led_q   <= led_d;
            tcmp_q  <= tcmp_d;
            hit_q   <= hit_d;
        end
    end

    assign led_out   = led_q;
    assign irq_timer = hit_q;
endmodule

// File: rtl/dmem_responder.sv
// Processor dmem responder: word RAM plus optional MMIO window (enabled by DMEM_MMIO_EN).
// Latency: one rising edge, write-first; never backpressures, one access accepted every cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LED_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 irq_timer
);
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  ram_we;
    logic                  is_mmio;
    logic [31:0]           mmio_rdata;
    logic [31:0]           q_dmem_q, q_dmem_d;
    logic                  unused_addr_bits;

    assign ram_idx = address_dmem[ADDR_WIDTH-1:0];

`ifdef DMEM_MMIO_EN
    assign is_mmio          = address_dmem[MMIO_SEL_BIT];
    assign unused_addr_bits = ^address_dmem[30:ADDR_WIDTH];

    dmem_mmio_regs #(
        .LED_WIDTH (LED_WIDTH)
    ) u_mmio (
        .clock     (clock),
        .reset     (reset),
        .sel       (is_mmio),
        .wren      (wren),
        .offset    (address_dmem[1:0]),
        .wdata     (data),
        .rdata     (mmio_rdata),
        .led_out   (led_out),
        .irq_timer (irq_timer)
    );
`else
    assign is_mmio          = 1'b0;
    assign unused_addr_bits = ^address_dmem[31:ADDR_WIDTH];
    assign mmio_rdata       = 32'd0;
    assign led_out          = '0;
    assign irq_timer        = 1'b0;
`endif

    // Gating with reset here drops any write that coincides with reset being low.
    assign ram_we = wren && !is_mmio && reset;

    always_ff @(posedge clock) begin
        if (ram_we) mem[ram_idx] <= data;
    end

    always_comb begin
        q_dmem_d = wren ? data : mem[ram_idx];
        if (is_mmio) q_dmem_d = mmio_rdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) q_dmem_q <= 32'd0;
        else        q_dmem_q <= q_dmem_d;
    end

    assign q_dmem = q_dmem_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; MMIO scenarios run when DMEM_MMIO_EN is defined.
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = 32'd0;
    logic [31:0] data = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [15:0] led_out;
    logic        irq_timer;

    int checks = 0;
    int fails  = 0;
    int unsigned tb_cycle;

    dmem_responder #(.ADDR_WIDTH(12), .LED_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .led_out      (led_out),
        .irq_timer    (irq_timer)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) tb_cycle <= 0;
        else        tb_cycle <= tb_cycle + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data         = d;
        wren         = w;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    task automatic test_reset_init();
        address_dmem = 32'd9;
        data         = 32'h5555_5555;
        wren         = 1'b1;
        #12;
        checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL reset_q q_dmem=%h expected 00000000", q_dmem); end
        checks++; if (led_out !== 16'd0) begin fails++; $display("FAIL reset_led led_out=%h expected 0000", led_out); end
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL reset_irq irq_timer=%b expected 0", irq_timer); end
        @(posedge clock); #1;
        wren  = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_ram();
        access(32'd5, 32'hDEAD_BEEF, 1'b1);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_write_first q_dmem=%h expected deadbeef", q_dmem); end
        access(32'd6, 32'h0, 1'b0);
        access(32'd5, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_read q_dmem=%h expected deadbeef", q_dmem); end
        access(32'd5 + 32'd4096, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ram_alias q_dmem=%h expected deadbeef", q_dmem); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_wr [3];
        logic [31:0] exp_rd [3];
        exp_wr[0] = 32'd1; exp_wr[1] = 32'd2; exp_wr[2] = 32'd3;
        exp_rd[0] = 32'd3; exp_rd[1] = 32'd2; exp_rd[2] = 32'd1;
        for (int i = 0; i < 3; i++) begin
            access(32'(i), exp_wr[i], 1'b1);
            checks++; if (q_dmem !== exp_wr[i]) begin fails++; $display("FAIL b2b_write%0d q_dmem=%h expected %h", i, q_dmem, exp_wr[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            access(32'(2 - i), 32'h0, 1'b0);
            checks++; if (q_dmem !== exp_rd[i]) begin fails++; $display("FAIL b2b_read%0d q_dmem=%h expected %h", i, q_dmem, exp_rd[i]); end
        end
    endtask

    task automatic test_reset_mid();
        access(32'd9, 32'h1111_2222, 1'b1);
        address_dmem = 32'd9;
        data         = 32'h9999_9999;
        wren         = 1'b1;
        reset        = 1'b0;
        #1;
        checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL midreset_q q_dmem=%h expected 00000000", q_dmem); end
        checks++; if (led_out !== 16'd0) begin fails++; $display("FAIL midreset_led led_out=%h expected 0000", led_out); end
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL midreset_irq irq_timer=%b expected 0", irq_timer); end
        repeat (2) @(posedge clock);
        #1;
        wren  = 1'b0;
        reset = 1'b1;
        access(32'd9, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'h1111_2222) begin fails++; $display("FAIL midreset_ram q_dmem=%h expected 11112222", q_dmem); end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_led();
        access(32'h8000_0001, 32'h0001_A5A5, 1'b1);
        checks++; if (q_dmem !== 32'h0000_A5A5) begin fails++; $display("FAIL led_wr_q q_dmem=%h expected 0000a5a5", q_dmem); end
        checks++; if (led_out !== 16'hA5A5) begin fails++; $display("FAIL led_out led_out=%h expected a5a5", led_out); end
        access(32'h8000_0001, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'h0000_A5A5) begin fails++; $display("FAIL led_rd q_dmem=%h expected 0000a5a5", q_dmem); end
    endtask

    task automatic test_timer();
        logic [31:0] tgt;
        access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (q_dmem !== tb_cycle) begin fails++; $display("FAIL cycle_rd q_dmem=%0d expected %0d", q_dmem, tb_cycle); end
        tgt = tb_cycle + 10;
        access(32'h8000_0002, tgt, 1'b1);
        checks++; if (q_dmem !== tgt) begin fails++; $display("FAIL tcmp_wr q_dmem=%0d expected %0d", q_dmem, tgt); end
        for (int n = 0; n < 64 && tb_cycle != tgt; n++) access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (q_dmem !== tgt) begin fails++; $display("FAIL timer_reach q_dmem=%0d expected %0d", q_dmem, tgt); end
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL timer_early irq_timer=%b expected 0", irq_timer); end
        access(32'h8000_0003, 32'h0, 1'b0);
        checks++; if (irq_timer !== 1'b1) begin fails++; $display("FAIL timer_hit irq_timer=%b expected 1", irq_timer); end
        checks++; if (q_dmem !== 32'd1) begin fails++; $display("FAIL status_rd q_dmem=%h expected 00000001", q_dmem); end
        repeat (3) access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (irq_timer !== 1'b1) begin fails++; $display("FAIL timer_sticky irq_timer=%b expected 1", irq_timer); end
        access(32'h8000_0003, 32'h1, 1'b1);
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL status_clr irq_timer=%b expected 0", irq_timer); end
        checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL status_clr_q q_dmem=%h expected 00000000", q_dmem); end
        tgt = tb_cycle + 5;
        access(32'h8000_0002, tgt, 1'b1);
        for (int n = 0; n < 64 && tb_cycle != tgt; n++) access(32'h8000_0000, 32'h0, 1'b0);
        access(32'h8000_0003, 32'h1, 1'b1);
        checks++; if (irq_timer !== 1'b1) begin fails++; $display("FAIL set_wins irq_timer=%b expected 1", irq_timer); end
        checks++; if (q_dmem !== 32'd1) begin fails++; $display("FAIL set_wins_q q_dmem=%h expected 00000001", q_dmem); end
        access(32'h8000_0002, 32'h0, 1'b1);
        access(32'h8000_0003, 32'h1, 1'b1);
        repeat (8) access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL tcmp_zero irq_timer=%b expected 0", irq_timer); end
    endtask

    task automatic test_wrap();
        force dut.u_mmio.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_mmio.cycle_q;
        access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'd0) begin fails++; $display("FAIL cycle_wrap q_dmem=%h expected 00000000", q_dmem); end
        access(32'h8000_0000, 32'd123, 1'b1);
        checks++; if (q_dmem !== 32'd1) begin fails++; $display("FAIL cycle_wr_ignored q_dmem=%h expected 00000001", q_dmem); end
    endtask
`else
    task automatic test_no_mmio();
        access(32'h8000_0003, 32'd7, 1'b1);
        checks++; if (q_dmem !== 32'd7) begin fails++; $display("FAIL nommio_wr q_dmem=%h expected 00000007", q_dmem); end
        access(32'd3, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'd7) begin fails++; $display("FAIL nommio_rd q_dmem=%h expected 00000007", q_dmem); end
        access(32'h8000_0000, 32'h0, 1'b0);
        checks++; if (q_dmem !== 32'd1) begin fails++; $display("FAIL nommio_ram0 q_dmem=%h expected 00000001", q_dmem); end
        checks++; if (irq_timer !== 1'b0) begin fails++; $display("FAIL nommio_irq irq_timer=%b expected 0", irq_timer); end
        checks++; if (led_out !== 16'd0) begin fails++; $display("FAIL nommio_led led_out=%h expected 0000", led_out); end
    endtask
`endif

    initial begin
        test_reset_init();
        test_ram();
        test_back_to_back();
`ifdef DMEM_MMIO_EN
        test_led();
`endif
        test_reset_mid();
`ifdef DMEM_MMIO_EN
        test_timer();
        test_wrap();
`else
        test_no_mmio();
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage pipelined processor: the memory-side end of the processor's dmem port (`address_dmem`, `data`, `wren`, `q_dmem`). It holds a word-addressed RAM and a small memory-mapped register window (cycle counter, LED register, timer compare, status). It answers every access with a fixed one-edge read latency, so the processor never stalls on dmem. It sits in the wrapper between the processor and the board I/O, replacing the bare dmem RAM.

## Interface
- `ADDR_WIDTH`, default 12: RAM depth is 2^ADDR_WIDTH 32-bit words.
- `LED_WIDTH`, default 16: width of the LED register and `led_out`.
- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `address_dmem`  in  32  word address from the processor.
- `data`  in  32  write data.
- `wren`  in  1  write strobe, sampled at the rising edge.
- `q_dmem`  out  32  registered read data.
- `led_out`  out  LED_WIDTH  LED register contents.
- `irq_timer`  out  1  sticky timer-hit flag (STATUS bit 0).

## Operation
- Region decode uses `address_dmem[31]`:
  - 0 selects RAM, indexed by `address_dmem[ADDR_WIDTH-1:0]`. Higher bits are ignored, so addresses alias and wrap modulo the depth.
  - 1 selects MMIO, indexed by `address_dmem[1:0]`. Bits [30:2] are ignored.
- RAM write: on a rising edge with `wren`=1, the word is stored.
- RAM read is write-first: when `wren`=1, the same edge loads `q_dmem` with the new `data`.
- MMIO registers, all resetting to 0:
  - 0 CYCLE: read-only, 32-bit free-running counter. Increments every edge and wraps 0xFFFF_FFFF→0. Writes are ignored.
  - 1 LED: read/write. Holds `data[LED_WIDTH-1:0]`; reads are zero-extended.
  - 2 TCMP: read/write, 32-bit timer compare value.
  - 3 STATUS: bit0 is `hit`, other bits read 0.
    - Writing 1 to bit0 clears `hit`; writing 0 has no effect.
- Timer hit: `hit` sets on the edge where the pre-increment CYCLE equals TCMP and TCMP≠0.
  - If set and clear occur on the same edge, set wins.
- MMIO read is write-first as well: a write to LED, TCMP or STATUS returns the post-write value on `q_dmem`. A write to CYCLE returns the incremented count.
- RAM contents are not cleared by reset; they power up undefined unless preloaded by simulation init.

## Timing
- Read latency: `q_dmem` is valid after the rising edge that sampled `address_dmem`. The processor launches on the falling edge and samples `q_dmem` on the next falling edge (half-cycle budget each way).
- `q_dmem` holds its value until the next rising edge, with or without an access. There is no idle or "valid" signal; every edge performs a read.
- Back-to-back accesses are allowed every cycle; throughput is 1 access per cycle.
- Reset asserted (`reset`=0), asynchronously:
  - `q_dmem`=0, `led_out`=0, `irq_timer`=0, CYCLE=0, TCMP=0.
  - RAM writes are suppressed while reset is low.
  - A write coincident with reset assertion is dropped.
- Reset released: the first rising edge with `reset`=1 increments CYCLE to 1 and performs the first access.
- `irq_timer` and `led_out` are driven directly from registers, with no combinational path from inputs.

## Configuration
- `DMEM_MMIO_EN` defined: MMIO decode, registers, `led_out` and `irq_timer` behave as above.
- `DMEM_MMIO_EN` undefined:
  - `address_dmem[31]` is ignored and every access goes to RAM.
  - `led_out` and `irq_timer` are tied to 0.
  - No MMIO or counter flops are synthesized.

## Structure
- Shared package `dmem_pkg`:
  - MMIO select bit index (31).
  - Register offsets CYCLE=0, LED=1, TCMP=2, STATUS=3.
  - STATUS bit index HIT=0.
- One sub-module, `dmem_mmio_regs`: the CYCLE counter, LED/TCMP/STATUS registers, the hit logic and the MMIO read mux. It is instantiated only under `DMEM_MMIO_EN`.
- The top level holds the RAM array, region decode and the `q_dmem` register/mux.

## Test plan
- **Reset:** hold `reset`=0 mid-run with `wren`=1 → `q_dmem`=0, `led_out`=0, `irq_timer`=0. The addressed RAM word is unchanged after release.
- **RAM write/read:**
  - Write 0xDEADBEEF to addr 5 → `q_dmem`=0xDEADBEEF on that edge (write-first).
  - Read addr 5 two cycles later → 0xDEADBEEF.
  - Read addr 5+4096 (ADDR_WIDTH=12) → 0xDEADBEEF (alias).
- **Back-to-back:** write 1,2,3 to addrs 0,1,2 on consecutive edges, then read 2,1,0 on consecutive edges → `q_dmem` sequence 3,2,1.
- **LED:** write 0x1_A5A5 to 0x8000_0001 → `led_out`=0xA5A5. A read returns 0x0000_A5A5.
- **Timer:**
  - Write TCMP=20 at CYCLE≈10 → `irq_timer` rises on the edge after CYCLE reads 20 and stays high.
  - Write 1 to STATUS → `irq_timer`=0.
  - TCMP=0 → `irq_timer` never sets.
- **Counter wrap and config:**
  - Force CYCLE=0xFFFF_FFFF → next read shows 0.
  - With `DMEM_MMIO_EN` undefined, write 7 to 0x8000_0003 → a read of addr 3 returns 7, and `irq_timer` stays 0.
